reprog_sequencer: RTL
=====================

REPROG_SEQUENCER -- requirements
Module: reprog_sequencer

Interface
REQ-001 SHALL have parameter PROG_PULSE_CYCLES, default 16: number of clock cycles cnet_prog_b is held low.
REQ-002 SHALL have parameter INIT_TIMEOUT, default 1024: maximum cycles to wait for cnet_init_b high after PROG release.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports ctrl_wr (input, 1): one-cycle register-write strobe for the reprogram control register; ctrl_start (input, 1): write data bit 0.
REQ-006 SHALL have ports data_wr (input, 1) and data_in (input, 32): data-register write strobe and the word to load.
REQ-007 SHALL have port data_ready, output, 1: the holding register can accept a word.
REQ-008 SHALL have ports cnet_prog_b (output, 1), cnet_init_b (input, 1) and cnet_done (input, 1): Virtex configuration control and status pins.
REQ-009 SHALL have ports cnet_cclk (output, 1), cnet_d (output, 8), cnet_cs_b (output, 1) and cnet_rdwr_b (output, 1): SelectMAP clock, data, chip-select and direction.
REQ-010 SHALL have outputs busy, done, err_timeout, err_crc and overflow, 1 bit each: status bits for register readback.

Function
REQ-011 SHALL implement states IDLE, PROG_LOW, WAIT_INIT, LOAD, DONE and ERROR.
REQ-012 SHALL move from any state to PROG_LOW on ctrl_wr with ctrl_start=1, clearing done, err_timeout, err_crc, overflow, the holding register and the byte counter.
REQ-013 SHALL, in PROG_LOW, drive cnet_prog_b=0 for exactly PROG_PULSE_CYCLES cycles, then go to WAIT_INIT.
REQ-014 SHALL, in WAIT_INIT, release cnet_prog_b=1 and go to LOAD on the first cycle cnet_init_b=1.
REQ-015 SHALL, in WAIT_INIT, go to ERROR with err_timeout=1 if cnet_init_b stays 0 for INIT_TIMEOUT cycles.
REQ-016 SHALL, in LOAD, drive cnet_cs_b=0 and cnet_rdwr_b=0; in all other states cnet_cs_b=1 and cnet_rdwr_b=0.
REQ-017 SHALL assert data_ready only in LOAD when the holding register is empty.
REQ-018 SHALL load data_in on data_wr while data_ready=1 and drop data_ready on the next cycle.
REQ-019 SHALL ignore data_wr while data_ready=0 and set sticky overflow=1.
REQ-020 SHALL serialise each word MSB byte first, 2 cycles per byte: cycle 2k drives cnet_cclk=0 with cnet_d=byte k; cycle 2k+1 drives cnet_cclk=1 with cnet_d held.
REQ-021 SHALL empty the holding register after the 4th byte's cclk-high cycle; data_ready reasserts on the following cycle.
REQ-022 SHALL, in LOAD, go to ERROR with err_crc=1 if cnet_init_b=0 is sampled, aborting the current word.
REQ-023 SHALL go to DONE and set done=1 when cnet_done=1 is sampled in LOAD, completing no further bytes.
REQ-024 SHALL give cnet_done priority over cnet_init_b=0 when both are sampled in the same LOAD cycle.
REQ-025 SHALL give a ctrl_start write priority over a simultaneous data_wr; that data word is dropped and overflow is not set.
REQ-026 SHALL ignore ctrl_wr with ctrl_start=0.
REQ-027 SHALL hold cnet_cclk=0 outside LOAD and assert busy=1 in PROG_LOW, WAIT_INIT and LOAD.

Reset
REQ-028 SHALL, on reset=1, enter IDLE with cnet_prog_b=1, cnet_cclk=0, cnet_d=0, cnet_cs_b=1, cnet_rdwr_b=0, data_ready=0, busy=0, done=0, all error flags 0, and all counters 0.
REQ-029 SHALL let a reset asserted mid-LOAD abort immediately; bytes already driven are not replayed.

Configuration
REQ-030 SHALL, with REPROG_BYTE_SWAP_EN defined, bit-reverse each byte on cnet_d (data bit 0 on cnet_d[7]); without it, cnet_d[7:0] equals the byte unchanged.

Structure
REQ-031 SHALL place the state encoding and the default parameter constants in shared package reprog_pkg.
REQ-032 SHALL implement the holding register, byte counter, cclk phase and byte-order logic as sub-module reprog_byte_shifter.

Verification
REQ-033 SHALL check start handshake: ctrl_start write, cnet_init_b high 5 cycles after release -> cnet_prog_b low exactly 16 cycles, then LOAD, data_ready=1.
REQ-034 SHALL check streaming: data_in=0x12345678 -> cnet_d 0x12,0x34,0x56,0x78 on 4 cclk rising edges, 8 cycles total; data_ready back 1 cycle later (or 0x48,0x2C,0x6A,0x1E with REPROG_BYTE_SWAP_EN).
REQ-035 SHALL check timeout: cnet_init_b held 0 -> err_timeout=1 and ERROR exactly 1024 cycles after entering WAIT_INIT.
REQ-036 SHALL check CRC and overflow: cnet_init_b driven 0 mid-word -> err_crc=1, cnet_cs_b=1; a second data_wr during serialisation -> overflow=1 and the word is dropped.
REQ-037 SHALL check completion and restart: cnet_done=1 after 4 words -> done=1, busy=0; a new ctrl_start -> all flags clear and PROG_LOW re-entered.

Source files
------------

// File: rtl/reprog_pkg.sv
// reprog_pkg
// Shared definitions for the Virtex SelectMAP reprogramming sequencer:
//   - reprog_state_t      : sequencer state encoding
//   - DEF_PROG_PULSE_CYCLES, DEF_INIT_TIMEOUT : default parameter values
//   - select_byte()       : pick byte k of a word, MSB byte first
//   - reverse_bits()      : mirror a byte (bit 0 <-> bit 7)
package reprog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROG_LOW  = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } reprog_state_t;

  localparam int DEF_PROG_PULSE_CYCLES = 16;
  localparam int DEF_INIT_TIMEOUT      = 1024;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      2'd3:    return word[7:0];
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] reverse_bits(input logic [7:0] b);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reprog_byte_shifter.sv
// reprog_byte_shifter
// Holding register plus byte serialiser for the SelectMAP data path.
// A word is accepted on load, then driven as 4 bytes, 2 cycles each
// (cclk low with new byte, then cclk high with the byte held).
// The register empties after the last cclk-high cycle.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   run             : sequencer stays in LOAD next cycle; low aborts the word
//   load, data_in   : accept strobe (only honoured while empty) and word
//   data_ready      : holding register empty while running
//   cclk, d         : SelectMAP clock and data byte
// Configuration: define REPROG_BYTE_SWAP_EN to bit-reverse each byte on d.
module reprog_byte_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic        data_ready,
  output logic        cclk,
  output logic [7:0]  d
);
  import reprog_pkg::*;

  logic [31:0] word_r;
  logic        full_r;
  logic [2:0]  cnt_r;      // [2:1] byte index, [0] cclk phase
  logic        ready_r;
  logic        cclk_r;
  logic [7:0]  d_r;
  logic [2:0]  cnt_next_s;

  function automatic logic [7:0] orient(input logic [7:0] b);
`ifdef REPROG_BYTE_SWAP_EN
    return reverse_bits(b);
`else
    return b;
`endif
  endfunction

  assign cnt_next_s = cnt_r + 3'd1;

  // Holding register, phase counter and registered SelectMAP outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r  <= 32'd0;
      full_r  <= 1'b0;
      cnt_r   <= 3'd0;
      ready_r <= 1'b0;
      cclk_r  <= 1'b0;
      d_r     <= 8'd0;
    end else if (!run) begin
      // Leaving LOAD (or never in it) drops any partial word; d keeps its last value.
      full_r  <= 1'b0;
      cnt_r   <= 3'd0;
      ready_r <= 1'b0;
      cclk_r  <= 1'b0;
    end else if (full_r) begin
      if (cnt_r == 3'd7) begin
        full_r  <= 1'b0;
        cnt_r   <= 3'd0;
        ready_r <= 1'b1;
        cclk_r  <= 1'b0;
      end else begin
        cnt_r   <= cnt_next_s;
        cclk_r  <= cnt_next_s[0];
        d_r     <= orient(select_byte(word_r, cnt_next_s[2:1]));
      end
    end else if (load) begin
      word_r  <= data_in;
      full_r  <= 1'b1;
      cnt_r   <= 3'd0;
      ready_r <= 1'b0;
      cclk_r  <= 1'b0;
      d_r     <= orient(select_byte(data_in, 2'd0));
    end else begin
      ready_r <= 1'b1;
      cclk_r  <= 1'b0;
    end
  end

  assign data_ready = ready_r;
  assign cclk       = cclk_r;
  assign d          = d_r;

endmodule

// File: rtl/reprog_sequencer.sv
// reprog_sequencer
// Drives a Virtex SelectMAP reconfiguration: PROG_B pulse, wait for INIT_B,
// then stream 32-bit words byte-wise until DONE, flagging INIT_B timeout,
// CRC error (INIT_B low while loading) and data-write overflow.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   ctrl_wr, ctrl_start            : control write strobe / start bit
//   data_wr, data_in, data_ready   : data word write interface
//   cnet_prog_b, cnet_init_b, cnet_done : configuration control/status pins
//   cnet_cclk, cnet_d, cnet_cs_b, cnet_rdwr_b : SelectMAP bus
//   busy, done, err_timeout, err_crc, overflow : status bits
// Configuration: REPROG_BYTE_SWAP_EN (see reprog_byte_shifter).
module reprog_sequencer
  import reprog_pkg::*;
#(
  parameter int PROG_PULSE_CYCLES = DEF_PROG_PULSE_CYCLES,
  parameter int INIT_TIMEOUT      = DEF_INIT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_wr,
  input  logic        ctrl_start,
  input  logic        data_wr,
  input  logic [31:0] data_in,
  output logic        data_ready,
  output logic        cnet_prog_b,
  input  logic        cnet_init_b,
  input  logic        cnet_done,
  output logic        cnet_cclk,
  output logic [7:0]  cnet_d,
  output logic        cnet_cs_b,
  output logic        cnet_rdwr_b,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_crc,
  output logic        overflow
);

  localparam logic [31:0] PULSE_LAST   = 32'(PROG_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(INIT_TIMEOUT - 1);

  reprog_state_t state_r;
  logic [31:0]   cnt_r;
  logic          prog_b_r, cs_b_r, busy_r, done_r, err_timeout_r, err_crc_r, overflow_r;
  logic          start_s, stay_load_s, enter_load_s, run_s, accept_s, data_ready_s;

  assign start_s      = ctrl_wr & ctrl_start;
  // DONE outranks INIT_B low; a start write outranks both.
  assign stay_load_s  = (state_r == ST_LOAD) & ~start_s & ~cnet_done & cnet_init_b;
  assign enter_load_s = (state_r == ST_WAIT_INIT) & ~start_s & cnet_init_b;
  assign run_s        = stay_load_s | enter_load_s;
  assign accept_s     = data_wr & data_ready_s & stay_load_s;

  reprog_byte_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .run        (run_s),
    .load       (accept_s),
    .data_in    (data_in),
    .data_ready (data_ready_s),
    .cclk       (cnet_cclk),
    .d          (cnet_d)
  );

  // Sequencer FSM with registered pin and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 32'd0;
      prog_b_r      <= 1'b1;
      cs_b_r        <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      err_crc_r     <= 1'b0;
      overflow_r    <= 1'b0;
    end else if (start_s) begin
      // Any concurrent data_wr is dropped without flagging overflow.
      state_r       <= ST_PROG_LOW;
      cnt_r         <= 32'd0;
      prog_b_r      <= 1'b0;
      cs_b_r        <= 1'b1;
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      err_crc_r     <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (data_wr && !data_ready_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        ST_PROG_LOW: begin
          if (cnt_r == PULSE_LAST) begin
            state_r  <= ST_WAIT_INIT;
            cnt_r    <= 32'd0;
            prog_b_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_WAIT_INIT: begin
          if (cnet_init_b) begin
            state_r <= ST_LOAD;
            cnt_r   <= 32'd0;
            cs_b_r  <= 1'b0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r       <= ST_ERROR;
            cnt_r         <= 32'd0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_LOAD: begin
          if (cnet_done) begin
            state_r <= ST_DONE;
            cs_b_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (!cnet_init_b) begin
            state_r   <= ST_ERROR;
            cs_b_r    <= 1'b1;
            busy_r    <= 1'b0;
            err_crc_r <= 1'b1;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          state_r <= state_r;
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= 32'd0;
          prog_b_r <= 1'b1;
          cs_b_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready  = data_ready_s;
  assign cnet_prog_b = prog_b_r;
  assign cnet_cs_b   = cs_b_r;
  assign cnet_rdwr_b = 1'b0;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_timeout = err_timeout_r;
  assign err_crc     = err_crc_r;
  assign overflow    = overflow_r;

endmodule
